// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keymap
// Description : Receives PS/2 keyboard frames and keeps a held/released level
//               for a small set of configured keys. It decodes Set-2 make and
//               break sequences, including E0-extended codes.
//
// Parameters  : NKEYS       - number of tracked keys (1..16)
//               KEY_CODES   - 9 bits per key; slice i = {E0 flag, make code}
//               TIMEOUT_CYC - idle clk cycles allowed between PS/2 falling
//                             edges inside a frame
// Ports       : clk         - system clock
//               rst         - synchronous active-high reset
//               ps2_clk     - asynchronous PS/2 clock
//               ps2_data    - asynchronous PS/2 data
//               keys        - per-key level, 1 while held
//               key_press   - one-cycle pulse on a key's 0->1 transition
//               frame_err   - one-cycle pulse on a rejected or timed-out frame
// Options     : PS2_KEYMAP_PRESS_PULSE_EN - when defined, key_press is
//               generated. When undefined, key_press is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keymap #(
    parameter int                 NKEYS       = 3,
    parameter logic [9*NKEYS-1:0] KEY_CODES   = {9'h174, 9'h16B, 9'h029},
    parameter int                 TIMEOUT_CYC = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] key_press,
    output logic             frame_err
);

    localparam int         c_TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------------
    // Synchronisers and falling-edge detect. All flops idle high, which
    // matches the bus idle level, so reset never creates a false edge.
    // ------------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;
    logic       w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];

    // ------------------------------------------------------------------------
    // Frame receiver. Bits are shifted in from the top. After 11 edges,
    // r_frame[0] holds the start bit and r_frame[10] holds the stop bit.
    // r_eval marks the cycle after the stop-bit edge, when the frame is judged.
    // ------------------------------------------------------------------------
    logic [3:0]      r_bitcnt;
    logic [10:0]     r_frame;
    logic            r_eval;
    logic [c_TW-1:0] r_tcnt;
    logic            w_timeout;

    // The timeout fires on the TIMEOUT_CYC-th consecutive idle cycle of a
    // partially received frame.
    assign w_timeout = ~w_fall && (r_bitcnt != 4'd0) && (r_tcnt == c_TLIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt <= 4'd0;
            r_frame  <= 11'h7FF;
            r_eval   <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_eval <= 1'b0;
            if (w_fall) begin
                r_frame <= {r_dat_sync[1], r_frame[10:1]};
                r_tcnt  <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= 4'd0;
                    r_eval   <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (w_timeout) begin
                    r_bitcnt <= 4'd0;
                    r_tcnt   <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    logic [7:0] w_byte;
    logic       w_frame_ok;
    logic       w_byte_done;
    logic       w_bad_frame;

    assign w_byte      = r_frame[8:1];
    // The 8 data bits plus the parity bit must contain an odd number of ones.
    assign w_frame_ok  = ~r_frame[0] & r_frame[10] & (^r_frame[9:1]);
    assign w_byte_done = r_eval & w_frame_ok;
    assign w_bad_frame = r_eval & ~w_frame_ok;

    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad_frame | w_timeout;
        end
    end

    assign frame_err = r_frame_err;

    // ------------------------------------------------------------------------
    // Make/break decoder
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t r_state;

    logic w_is_e0;
    logic w_is_f0;
    logic w_ext;
    logic w_rel;
    logic w_ignore;
    logic w_is_code;
    logic [8:0] w_code;

    assign w_is_e0 = (w_byte == 8'hE0);
    assign w_is_f0 = (w_byte == 8'hF0);
    assign w_ext   = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    assign w_rel   = (r_state == S_BRK) || (r_state == S_EXT_BRK);
    assign w_code  = {w_ext, w_byte};

    // These bytes are controller responses or error codes, not key codes.
    assign w_ignore = (w_byte == 8'h00) || (w_byte == 8'hAA) ||
                      (w_byte == 8'hEE) || (w_byte == 8'hFA) ||
                      (w_byte == 8'hFE) || (w_byte == 8'hFF);

    // An E0 that follows a bare F0 does not start an extended sequence.
    // It is handled as an ordinary code byte that matches nothing and
    // returns the decoder to idle.
    assign w_is_code = w_byte_done & ~w_is_f0 &
                       ~(w_is_e0 && (r_state != S_BRK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (w_bad_frame) begin
            r_state <= S_IDLE;
        end else if (w_byte_done) begin
            if (w_is_f0) begin
                case (r_state)
                    S_IDLE:  r_state <= S_BRK;
                    S_EXT:   r_state <= S_EXT_BRK;
                    default: r_state <= r_state;
                endcase
            end else if (w_is_e0 && (r_state != S_BRK)) begin
                r_state <= S_EXT;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Key matching. Every slot whose code matches is updated, so duplicate
    // codes in KEY_CODES all follow the same physical key.
    // ------------------------------------------------------------------------
    logic [NKEYS-1:0] w_match;

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_match
        assign w_match[gi] = w_is_code && ~w_ignore &&
                             (KEY_CODES[9*gi +: 9] == w_code);
    end

    logic [NKEYS-1:0] r_keys;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys <= '0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (w_match[i]) begin
                    r_keys[i] <= ~w_rel;
                end
            end
        end
    end

    assign keys = r_keys;

`ifdef PS2_KEYMAP_PRESS_PULSE_EN
    // The pulse register updates on the same edge as r_keys. It is high in
    // exactly the first cycle a key reads 1. Typematic repeats find the key
    // already set, so they produce no pulse.
    logic [NKEYS-1:0] r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_press <= '0;
        end else begin
            r_press <= (w_rel ? '0 : w_match) & ~r_keys;
        end
    end

    assign key_press = r_press;
`else
    assign key_press = '0;
`endif

endmodule
`default_nettype wire

// File: doc/ps2_keymap.md
PS2_KEYMAP -- requirements
Module: ps2_keymap

Interface
REQ-001 Parameter NKEYS, default 3, number of tracked keys (1..16).
REQ-002 Parameter KEY_CODES, width 9*NKEYS, default {9'h174, 9'h16B, 9'h029}; slice i holds key i's code: bit 8 is the E0-extended flag, bits 7:0 the make code (key0 space, key1 left arrow, key2 right arrow).
REQ-003 Parameter TIMEOUT_CYC, default 5000, idle clk cycles allowed between PS/2 falling edges inside a frame.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock from the keyboard.
REQ-007 ps2_data  input  1  asynchronous PS/2 data from the keyboard.
REQ-008 keys  output  NKEYS  level per key: 1 while held.
REQ-009 key_press  output  NKEYS  one-cycle pulse on a key's 0->1 transition.
REQ-010 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge is the synchronised clock going 1->0.
REQ-012 Receiver SHALL sample data on each falling edge into an 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1; 4-bit bit counter 0..10.
REQ-013 byte_done SHALL assert for one cycle, one cycle after the falling edge that samples the stop bit, only if start=0, stop=1 and parity is odd.
REQ-014 A bad start, stop or parity bit SHALL discard the byte, pulse frame_err, and return the decoder to IDLE.
REQ-015 Bit counter nonzero with no falling edge for TIMEOUT_CYC cycles SHALL discard the partial frame, reset the counter to 0 and pulse frame_err; the decoder state is unchanged.
REQ-016 Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-017 Transitions on byte_done: E0 from IDLE->EXT; F0 from IDLE->BRK; F0 from EXT->EXT_BRK; any other byte is a code byte -> IDLE.
REQ-018 Code byte: code={ext,byte}, ext=1 in EXT/EXT_BRK, release=1 in BRK/EXT_BRK.
REQ-019 Every i with KEY_CODES[i]==code SHALL update keys[i]<=~release on the clk edge after byte_done; duplicate codes update all matching keys.
REQ-020 Unmatched codes and 00, AA, EE, FA, FE, FF SHALL not change keys.
REQ-021 Typematic repeats of a held key SHALL keep keys[i]=1 and produce no key_press.
REQ-022 Release of a key not held SHALL leave keys[i]=0.
REQ-023 key_press[i] SHALL be high exactly in the cycle keys[i] first reads 1.
REQ-024 E0 in EXT or EXT_BRK SHALL go to EXT; F0 in BRK or EXT_BRK SHALL keep the current state.

Reset
REQ-025 On rst: keys, key_press, frame_err=0; FSM=IDLE; bit counter and timeout counter=0; synchroniser flops=1.
REQ-026 rst during a frame SHALL discard it with no keys change; reception resumes on the next start bit after rst deasserts.

Configuration
REQ-027 Macro PS2_KEYMAP_PRESS_PULSE_EN: defined -> key_press behaves per REQ-023; undefined -> key_press is tied to constant 0 and the edge-detect registers are not built.

Verification
REQ-028 Frame 29 with good parity -> keys=3'b001, key_press=3'b001 for 1 cycle; then F0 29 -> keys=3'b000.
REQ-029 E0 6B, then E0 6B repeated 3 times -> keys=3'b010, exactly one key_press[1] pulse; E0 F0 6B -> keys=3'b000.
REQ-030 Non-extended 6B (keypad 4) -> keys unchanged at 3'b000; E0 74 -> keys=3'b100.
REQ-031 Frame 29 with even parity -> frame_err one pulse, keys=3'b000; E0 then bad-stop frame, then 29 -> decoded as non-extended, keys=3'b001.
REQ-032 5 bits of a frame, then ps2_clk held high for TIMEOUT_CYC+1 cycles -> frame_err pulse; next full frame 29 -> keys=3'b001.
REQ-033 Hold 29 (keys=3'b001), assert rst mid-frame of F0 -> keys=3'b000, FSM IDLE; next frame 74 -> keys unchanged (non-extended code unmatched).
